// File: rtl/vram_blitter.sv
// vram_blitter: write-side VRAM engine. It fills the whole canvas with one
// colour, or copies an SPR x SPR sprite from a synchronous sprite ROM to (x,y)
// with transparency (colour KEY) and edge clipping. It writes one pixel per clock.
//
// Optional build macro: BLIT_FLIP_EN. When it is defined, a latched cmd_flip
// mirrors the sprite horizontally. When it is undefined, cmd_flip is ignored.
//
// Command handshake: a command transfers on a clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE. cmd_valid may be
// held or dropped freely while cmd_ready is low, and nothing is latched then.
module vram_blitter #(
    parameter int          DW    = 15,
    parameter int          H_LEN = 200,
    parameter int          V_LEN = 150,
    parameter int          SPR   = 16,
    parameter int          SAW   = 10,
    parameter logic [11:0] KEY   = 12'hF0F
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_op,
    input  logic [7:0]     cmd_x,
    input  logic [7:0]     cmd_y,
    input  logic [1:0]     cmd_sid,
    input  logic [11:0]    cmd_color,
    input  logic           cmd_flip,
    output logic [SAW-1:0] rom_addr,
    input  logic [11:0]    rom_data,
    output logic           we,
    output logic [DW-1:0]  waddr,
    output logic [11:0]    wdata,
    output logic           busy,
    output logic           done
);

    localparam int            SB       = $clog2(SPR);
    localparam logic [DW-1:0] PIX_LAST = DW'(H_LEN * V_LEN - 1);
    localparam logic [DW-1:0] H_STEP   = DW'(H_LEN);
    localparam logic [8:0]    H_LIM    = 9'(H_LEN);
    localparam logic [8:0]    V_LIM    = 9'(V_LEN);
    localparam logic [SB-1:0] CNT_LAST = SB'(SPR - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_BLIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched command fields.
    logic [7:0]    r_x;
    logic [7:0]    r_y;
    logic [1:0]    r_sid;
    logic [11:0]   r_color;

    // Sprite walk: i = column, j = row, row-major order.
    logic [SB-1:0] r_i;
    logic [SB-1:0] r_j;
    logic [DW-1:0] r_row_base;
    logic [DW-1:0] r_fill_addr;

    // One-stage write pipeline that lines up with the ROM read latency.
    logic          r_p_valid;
    logic [DW-1:0] r_p_addr;

    logic          r_done;
    logic [DW-1:0] r_waddr_hold;
    logic [11:0]   r_wdata_hold;

    logic [SB-1:0] w_col_src;
    logic [8:0]    w_col_sum;
    logic [8:0]    w_row_sum;
    logic          w_clip;
    logic [DW-1:0] w_pix_addr;
    logic          w_blit_last;
    logic          w_fill_last;
    logic          w_we;
    logic [DW-1:0] w_waddr;
    logic [11:0]   w_wdata;

`ifdef BLIT_FLIP_EN
    logic          r_flip;
    // For a power-of-two SPR, SPR-1-i is the bitwise inverse of i.
    assign w_col_src = r_flip ? ~r_i : r_i;
`else
    logic          w_unused_flip;
    assign w_unused_flip = cmd_flip;
    assign w_col_src     = r_i;
`endif

    // The ROM base is sid*SPR*SPR, so the read address is a plain concatenation.
    assign rom_addr    = SAW'({r_sid, r_j, w_col_src});

    // Destination column and row are 9 bits wide, so edge overflow is visible to the clip test.
    assign w_col_sum   = {1'b0, r_x} + 9'(r_i);
    assign w_row_sum   = {1'b0, r_y} + 9'(r_j);
    assign w_clip      = (w_col_sum >= H_LIM) || (w_row_sum >= V_LIM);
    assign w_pix_addr  = r_row_base + DW'(w_col_sum);
    assign w_blit_last = (r_i == CNT_LAST) && (r_j == CNT_LAST);
    assign w_fill_last = (r_fill_addr == PIX_LAST);

    assign we    = w_we;
    assign waddr = w_waddr;
    assign wdata = w_wdata;
    assign done  = r_done;
    assign busy  = ~cmd_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and command handshake.
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = cmd_op ? S_FILL : S_BLIT;
                end
            end
            S_FILL: begin
                if (w_fill_last) begin
                    w_next = S_IDLE;
                end
            end
            S_BLIT: begin
                if (w_blit_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Write port: a fill writes directly, and a blit writes the ROM data returned for the previous read.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_waddr_hold;
        w_wdata = r_wdata_hold;
        if (r_state == S_FILL) begin
            w_we    = 1'b1;
            w_waddr = r_fill_addr;
            w_wdata = r_color;
        end else if (r_p_valid && (rom_data != KEY)) begin
            w_we    = 1'b1;
            w_waddr = r_p_addr;
            w_wdata = rom_data;
        end
    end

    // Datapath: command latch, counters, write pipeline, done pulse and held write values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_sid        <= '0;
            r_color      <= '0;
            r_i          <= '0;
            r_j          <= '0;
            r_row_base   <= '0;
            r_fill_addr  <= '0;
            r_p_valid    <= 1'b0;
            r_p_addr     <= '0;
            r_done       <= 1'b0;
            r_waddr_hold <= '0;
            r_wdata_hold <= '0;
`ifdef BLIT_FLIP_EN
            r_flip       <= 1'b0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_p_valid <= 1'b0;
            if (w_we) begin
                r_waddr_hold <= w_waddr;
                r_wdata_hold <= w_wdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_x         <= cmd_x;
                        r_y         <= cmd_y;
                        r_sid       <= cmd_sid;
                        r_color     <= cmd_color;
                        r_i         <= '0;
                        r_j         <= '0;
                        r_fill_addr <= '0;
                        // This constant multiply runs once per command, not once per pixel.
                        r_row_base  <= DW'(cmd_y) * H_STEP;
`ifdef BLIT_FLIP_EN
                        r_flip      <= cmd_flip;
`endif
                    end
                end
                S_FILL: begin
                    r_fill_addr <= r_fill_addr + 1'b1;
                    if (w_fill_last) begin
                        r_done <= 1'b1;
                    end
                end
                S_BLIT: begin
                    // A clipped pixel still uses its read slot, but it is never written.
                    r_p_valid <= ~w_clip;
                    r_p_addr  <= w_pix_addr;
                    r_i       <= r_i + 1'b1;
                    if (r_i == CNT_LAST) begin
                        r_j        <= r_j + 1'b1;
                        r_row_base <= r_row_base + H_STEP;
                    end
                end
                S_DRAIN: begin
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_blitter.sv
// Testbench for vram_blitter. A cycle-level reference model computes each
// cycle's expected write from the command, the time since it was accepted,
// and the sprite ROM image. Directed commands drive the DUT, and literal
// expectations pin the model.
module tb_vram_blitter;

    localparam int          DW    = 15;
    localparam int          H_LEN = 200;
    localparam int          V_LEN = 150;
    localparam int          SPR   = 16;
    localparam int          SAW   = 10;
    localparam logic [11:0] KEY   = 12'hF0F;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_op;
    logic [7:0]     cmd_x;
    logic [7:0]     cmd_y;
    logic [1:0]     cmd_sid;
    logic [11:0]    cmd_color;
    logic           cmd_flip;
    logic [SAW-1:0] rom_addr;
    logic [11:0]    rom_data = 12'h000;
    logic           we;
    logic [DW-1:0]  waddr;
    logic [11:0]    wdata;
    logic           busy;
    logic           done;

    vram_blitter #(
        .DW(DW), .H_LEN(H_LEN), .V_LEN(V_LEN), .SPR(SPR), .SAW(SAW), .KEY(KEY)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_sid(cmd_sid),
        .cmd_color(cmd_color), .cmd_flip(cmd_flip),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done)
    );

    // Clock and synchronous sprite ROM.
    always #5 clk = ~clk;

    logic [11:0] rom [0:4*SPR*SPR-1];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Counters
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model state for the command in flight.
    logic          chk_en = 1'b0;
    logic          m_active = 1'b0;
    logic          m_op;
    int            m_t0;
    int            m_x, m_y, m_sid;
    logic [11:0]   m_color;
    logic          m_flip;
    logic [DW-1:0] m_last_addr = '0;
    logic [11:0]   m_last_data = '0;

    // Per-command observations used by the literal checks.
    int          r_writes, r_first_addr, r_last_addr, r_max_addr, r_done_rel, r_done_cnt;
    logic [11:0] r_first_data, r_last_data, r_d0, r_d15;

    // Compare process: it checks every output against the model on each falling edge.
    always @(negedge clk) begin
        int rel, k, i, j, src, col, row, done_rel;
        logic exp_we, exp_done, exp_ready;
        logic [DW-1:0] ea;
        logic [11:0] ed;
        if (chk_en) begin
            exp_we = 1'b0; exp_done = 1'b0; exp_ready = 1'b1;
            ea = m_last_addr; ed = m_last_data;
            rel = 0;
            if (m_active) begin
                rel       = cyc - m_t0 + 1;
                done_rel  = m_op ? H_LEN * V_LEN + 1 : SPR * SPR + 2;
                exp_ready = (rel >= done_rel);
                exp_done  = (rel == done_rel);
                if (m_op) begin
                    if (rel >= 1 && rel <= H_LEN * V_LEN) begin
                        exp_we = 1'b1; ea = DW'(rel - 1); ed = m_color;
                    end
                end else if (rel >= 2 && rel <= SPR * SPR + 1) begin
                    k = rel - 2; i = k % SPR; j = k / SPR; src = i;
`ifdef BLIT_FLIP_EN
                    if (m_flip) src = SPR - 1 - i;
`endif
                    col = m_x + i; row = m_y + j;
                    if (col < H_LEN && row < V_LEN && rom[m_sid * SPR * SPR + j * SPR + src] != KEY) begin
                        exp_we = 1'b1;
                        ea = DW'(row * H_LEN + col);
                        ed = rom[m_sid * SPR * SPR + j * SPR + src];
                    end
                end
            end
            check("we", int'(we), int'(exp_we));
            check("cmd_ready", int'(cmd_ready), int'(exp_ready));
            check("busy", int'(busy), int'(!exp_ready));
            check("done", int'(done), int'(exp_done));
            check("waddr", int'(waddr), int'(ea));
            check("wdata", int'(wdata), int'(ed));
            if (exp_we) begin m_last_addr = ea; m_last_data = ed; end
            if (we) begin
                if (r_writes == 0) begin r_first_addr = int'(waddr); r_first_data = wdata; end
                r_writes++;
                r_last_addr = int'(waddr); r_last_data = wdata;
                if (int'(waddr) > r_max_addr) r_max_addr = int'(waddr);
                if (waddr == 0) r_d0 = wdata;
                if (waddr == 15) r_d15 = wdata;
            end
            if (done) begin r_done_cnt++; r_done_rel = rel; end
            if (m_active && exp_done) m_active = 1'b0;
        end
    end

    // Driver: it waits for cmd_ready, presents a command for one edge, then arms the model.
    task automatic issue(input logic op, input int x, input int y, input int sid,
                         input logic [11:0] color, input logic flip);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 40000) begin @(negedge clk); n++; end
        check("accept_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_x = 8'(x); cmd_y = 8'(y);
        cmd_sid = 2'(sid); cmd_color = color; cmd_flip = flip;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        m_op = op; m_x = x; m_y = y; m_sid = sid; m_color = color; m_flip = flip;
        m_t0 = cyc; m_active = 1'b1;
        r_writes = 0; r_max_addr = -1; r_done_cnt = 0; r_done_rel = -1;
        r_first_addr = -1; r_last_addr = -1;
        r_first_data = 12'hFFF; r_last_data = 12'hFFF; r_d0 = 12'hFFF; r_d15 = 12'hFFF;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 40000 && m_active; n++) begin @(posedge clk); #1; end
        check("cmd_complete", int'(m_active), 0);
    endtask

    initial begin
        int ta;
        for (int a = 0; a < 4 * SPR * SPR; a++) rom[a] = 12'(a);
        for (int j = 0; j < SPR; j++) rom[2 * SPR * SPR + j * SPR] = KEY;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_x = '0; cmd_y = '0;
        cmd_sid = '0; cmd_color = '0; cmd_flip = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", int'(we), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_wdata", int'(wdata), 0);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_done", int'(done), 0);
        check("rst_ready", int'(cmd_ready), 1);
        rst = 1'b0; m_last_addr = '0; m_last_data = '0; chk_en = 1'b1;

        // Full-canvas fill.
        issue(1'b1, 0, 0, 0, 12'h123, 1'b0);
        wait_idle();
        check("fill_writes", r_writes, 30000);
        check("fill_first_addr", r_first_addr, 0);
        check("fill_last_addr", r_last_addr, 29999);
        check("fill_data", int'(r_last_data), 12'h123);
        check("fill_done_rel", r_done_rel, 30001);
        check("fill_done_cnt", r_done_cnt, 1);

        // Sprite 1 placed fully on screen.
        issue(1'b0, 10, 20, 1, 12'h000, 1'b0);
        wait_idle();
        check("blit_writes", r_writes, 256);
        check("blit_first_addr", r_first_addr, 4010);
        check("blit_first_data", int'(r_first_data), 256);
        check("blit_last_addr", r_last_addr, 7025);
        check("blit_last_data", int'(r_last_data), 511);
        check("blit_done_rel", r_done_rel, 258);

        // Sprite clipped at the bottom-right corner.
        issue(1'b0, 192, 145, 1, 12'h000, 1'b0);
        wait_idle();
        check("clip_writes", r_writes, 40);
        check("clip_max_addr_in_range", int'(r_max_addr < 30000), 1);
        check("clip_max_addr", r_max_addr, 149 * 200 + 199);
        check("clip_done_rel", r_done_rel, 258);

        // Transparent pixels in column 0 of sprite 2.
        issue(1'b0, 50, 50, 2, 12'h000, 1'b0);
        wait_idle();
        check("key_writes", r_writes, 240);
        check("key_first_addr", r_first_addr, 50 * 200 + 51);
        check("key_first_data", int'(r_first_data), 513);

        // Back-to-back blits: the second command is accepted on the done edge of the first.
        issue(1'b0, 100, 100, 1, 12'h000, 1'b0);
        ta = m_t0;
        issue(1'b0, 0, 140, 2, 12'h000, 1'b0);
        check("b2b_accept_gap", m_t0 - ta, 258);
        wait_idle();
        check("b2b_writes", r_writes, 10 * 15);

        // Reset in the middle of a blit.
        issue(1'b0, 10, 20, 1, 12'h000, 1'b0);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (cyc - m_t0 + 1 == 100) break;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        m_active = 1'b0; m_last_addr = '0; m_last_data = '0; r_done_cnt = 0;
        @(negedge clk);
        check("abort_rom_addr", int'(rom_addr), 0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("abort_no_done", r_done_cnt, 0);
        issue(1'b1, 0, 0, 0, 12'hABC, 1'b0);
        wait_idle();
        check("post_abort_fill_writes", r_writes, 30000);
        check("post_abort_fill_done", r_done_cnt, 1);

        // Flip request on sprite 0 at the origin.
        issue(1'b0, 0, 0, 0, 12'h000, 1'b1);
        wait_idle();
`ifdef BLIT_FLIP_EN
        check("flip_addr0_data", int'(r_d0), 15);
        check("flip_addr15_data", int'(r_d15), 0);
`else
        check("noflip_addr0_data", int'(r_d0), 0);
        check("noflip_addr15_data", int'(r_d15), 15);
`endif
        check("flip_writes", r_writes, 256);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_blitter.md
Name: vram_blitter

Overview:
- Write-side counterpart of the display fetch path. The display path reads the canvas VRAM (H_LEN x V_LEN, 12-bit RGB, linear row-major address) to drive the screen.
- This block writes that same VRAM, on the VRAM write port.
- It accepts draw commands from game logic: a full-canvas colour fill, or a SPR x SPR sprite copied from a sprite ROM to (x,y). Sprites support transparency and edge clipping.
- One pixel is written per clock.

Parameters:
- DW, 15, VRAM address width; must hold H_LEN*V_LEN-1.
- H_LEN, 200, canvas width in pixels.
- V_LEN, 150, canvas height in pixels.
- SPR, 16, sprite side length in pixels (power of two).
- SAW, 10, sprite ROM address width = log2(4*SPR*SPR).
- KEY, 12'hF0F, transparent colour key.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when idle; a command is accepted on cmd_valid && cmd_ready.
- cmd_op  in  1  0 = blit sprite, 1 = fill canvas.
- cmd_x  in  8  sprite left column.
- cmd_y  in  8  sprite top row.
- cmd_sid  in  2  sprite index; ROM base = cmd_sid*SPR*SPR.
- cmd_color  in  12  fill colour.
- cmd_flip  in  1  horizontal mirror request (see Optional Feature).
- rom_addr  out  SAW  sprite ROM read address; synchronous ROM, data returns 1 cycle later.
- rom_data  in  12  sprite ROM read data.
- we  out  1  VRAM write enable.
- waddr  out  DW  VRAM write address.
- wdata  out  12  VRAM write data.
- busy  out  1  ~cmd_ready.
- done  out  1  1-cycle pulse on command completion.

Behaviour:
- Reset (rst high at a clk edge): state IDLE. cmd_ready=1, we=0, waddr=0, wdata=0, rom_addr=0, done=0.
- Reset mid-command aborts the command: no further writes and no done pulse.
- States: IDLE, FILL, BLIT, DRAIN.
- IDLE: cmd_ready=1. On accept, latch all cmd_* fields, drop cmd_ready at the same edge, and go to FILL or BLIT per cmd_op.
- FILL: first write in cycle 1 after accept. Writes we=1, wdata=cmd_color, waddr=0,1,...,H_LEN*V_LEN-1, one per cycle (30000 writes at defaults).
  - After the last write, done=1 for exactly 1 cycle, then IDLE.
- BLIT: counters i (column) and j (row), each 0..SPR-1, row-major. One ROM read is issued per cycle, starting in cycle 1 after accept: rom_addr = base + j*SPR + i.
  - After the final read (i=j=SPR-1), go to DRAIN for one cycle to consume the last ROM return.
- Write pipeline: a valid bit and the pixel's target address are delayed 1 cycle to align with rom_data.
  - Pixel (i,j) is written in the cycle after its read: we=1, wdata=rom_data, waddr=(cmd_y+j)*H_LEN+(cmd_x+i).
- Address generation is incremental. A row-base register starts at cmd_y*H_LEN and adds H_LEN per row. No multiplier in the per-pixel path.
- Clipping: column sum cmd_x+i and row sum cmd_y+j are computed 9 bits wide.
  - If column >= H_LEN or row >= V_LEN, that pixel's we=0.
  - Read timing is unchanged: clipped pixels still consume their cycle.
- Transparency: if rom_data==KEY, we=0 for that pixel.
- Blit timing: completes a fixed 1+SPR*SPR cycles after accept regardless of clipping or transparency. done pulses the cycle after the last write slot, i.e. SPR*SPR+2 cycles after accept.
- Back-to-back commands: cmd_ready returns high in the cycle done is asserted. A new command can be accepted at that edge; no bubble beyond this.
- When we=0, waddr and wdata hold their last values.
- Every cycle has exactly one writer, so there are no write collisions.

Optional Feature:
- Macro BLIT_FLIP_EN.
- Defined: when the latched cmd_flip=1, the ROM column index becomes SPR-1-i. Destination column stays cmd_x+i, so the sprite is mirrored horizontally. Clipping and transparency still apply per destination pixel.
- Undefined: cmd_flip is ignored and rom_addr always uses column i.
- Timing is identical in both builds.

Test Plan:
- Reset, then fill cmd_color=12'h123 -> we high for exactly 30000 consecutive cycles, waddr 0..29999, wdata=12'h123. done pulses once on cycle 30001; cmd_ready high the same cycle.
- Blit sid=1 at (10,20), ROM pixel value = its index, no KEY -> 256 writes. First write waddr=20*200+10=4010, wdata=ROM[256]. Last write waddr=35*200+25=7025. done at cycle 258 after accept.
- Blit at (192,145) -> only pixels with column < 200 and row < 150 written: 8x5 = 40 writes, no address ≥ 30000. done still at cycle 258.
- Sprite with ROM pixels at i=0 equal to 12'hF0F -> we=0 for column 0 of every row; all other pixels written.
- Assert rst during a blit at cycle 100 -> we=0 from the next edge, no done pulse, cmd_ready=1. A fresh fill is then accepted and completes normally.
- BLIT_FLIP_EN defined, cmd_flip=1, sid=0 at (0,0) -> pixel written to waddr 0 carries ROM[15], waddr 15 carries ROM[0].
